// File: rtl/bp_me_nonsynth_mock_cce_responder.sv
// Mock single-CCE responder for LCE unit tests.
// Accepts one LCE request at a time, answers it with one LCE command after a
// fixed latency, and for cached fills waits for the matching coherence ack.
// Fill data is derived from the address so data can be checked end to end.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   lce_req_*             request channel from the LCE (valid/ready)
//   lce_resp_*            response channel from the LCE (always sunk)
//   lce_cmd_*             command channel to the LCE (valid/ready)
//   error_o               sticky protocol-violation flag
//   txn_count_o           completed transactions, wraps at 2^32

package bp_me_nonsynth_mock_cce_responder_pkg;

    typedef enum logic [0:0] {
        e_bp_unicore_half_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned paddr_width_gp     = 40;
    localparam int unsigned lce_id_width_gp    = 4;
    localparam int unsigned cce_id_width_gp    = 4;
    localparam int unsigned lce_assoc_gp       = 8;
    localparam int unsigned way_id_width_gp    = $clog2(lce_assoc_gp);
    localparam int unsigned cce_block_width_gp = 512;

    typedef enum logic [2:0] {
        e_lce_req_type_rd    = 3'd0,
        e_lce_req_type_wr    = 3'd1,
        e_lce_req_type_uc_rd = 3'd2,
        e_lce_req_type_uc_wr = 3'd3
    } bp_lce_cce_req_type_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'd0,
        e_mem_msg_size_2  = 3'd1,
        e_mem_msg_size_4  = 3'd2,
        e_mem_msg_size_8  = 3'd3,
        e_mem_msg_size_16 = 3'd4,
        e_mem_msg_size_32 = 3'd5,
        e_mem_msg_size_64 = 3'd6
    } bp_mem_msg_size_e;

    typedef enum logic [2:0] {
        e_lce_cce_sync_ack     = 3'd0,
        e_lce_cce_inv_ack      = 3'd1,
        e_lce_cce_coh_ack      = 3'd2,
        e_lce_cce_resp_wb      = 3'd3,
        e_lce_cce_resp_null_wb = 3'd4
    } bp_lce_cce_resp_type_e;

    typedef enum logic [3:0] {
        e_lce_cmd_sync        = 4'd0,
        e_lce_cmd_inv         = 4'd1,
        e_lce_cmd_data        = 4'd2,
        e_lce_cmd_uc_data     = 4'd3,
        e_lce_cmd_uc_st_done  = 4'd4
    } bp_lce_cmd_type_e;

    typedef enum logic [2:0] {
        e_COH_I = 3'd0,
        e_COH_S = 3'd1,
        e_COH_E = 3'd2,
        e_COH_F = 3'd3,
        e_COH_M = 3'd6,
        e_COH_O = 3'd7
    } bp_coh_states_e;

    typedef struct packed {
        bp_lce_cce_req_type_e         msg_type;
        bp_mem_msg_size_e             size;
        logic [paddr_width_gp-1:0]    addr;
        logic [lce_id_width_gp-1:0]   src_id;
        logic [way_id_width_gp-1:0]   lru_way_id;
        logic                         non_exclusive;
    } bp_lce_cce_req_s;

    typedef struct packed {
        bp_lce_cce_resp_type_e        msg_type;
        logic [paddr_width_gp-1:0]    addr;
        logic [lce_id_width_gp-1:0]   src_id;
    } bp_lce_cce_resp_s;

    typedef struct packed {
        bp_lce_cmd_type_e             msg_type;
        logic [lce_id_width_gp-1:0]   dst_id;
        logic [cce_id_width_gp-1:0]   src_id;
        logic [paddr_width_gp-1:0]    addr;
        logic [way_id_width_gp-1:0]   way_id;
        bp_coh_states_e               state;
        bp_mem_msg_size_e             size;
        logic [cce_block_width_gp-1:0] data;
    } bp_lce_cmd_s;

    // Block width for a processor configuration.
    function automatic int unsigned bp_cfg_block_width(input bp_params_e cfg);
        case (cfg)
            e_bp_unicore_half_cfg: return cce_block_width_gp;
            default:               return cce_block_width_gp;
        endcase
    endfunction

endpackage

module bp_me_nonsynth_mock_cce_responder
    import bp_me_nonsynth_mock_cce_responder_pkg::*;
#(
    parameter bp_params_e  bp_params_p   = e_bp_unicore_half_cfg,
    parameter int unsigned cmd_latency_p = 2,
    parameter logic [63:0] data_seed_p   = 64'h0,
    localparam int unsigned lce_cce_req_width_lp  = $bits(bp_lce_cce_req_s),
    localparam int unsigned lce_cce_resp_width_lp = $bits(bp_lce_cce_resp_s),
    localparam int unsigned lce_cmd_width_lp      = $bits(bp_lce_cmd_s)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [lce_cce_req_width_lp-1:0]  lce_req_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_ready_o,
    input  logic [lce_cce_resp_width_lp-1:0] lce_resp_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_ready_o,
    output logic [lce_cmd_width_lp-1:0]      lce_cmd_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_ready_i,
    output logic                             error_o,
    output logic [31:0]                      txn_count_o
);

    localparam int unsigned cce_block_width_p = bp_cfg_block_width(bp_params_p);
    localparam int unsigned dwords_lp         = cce_block_width_p / 64;
    localparam int unsigned blk_off_w_lp      = $clog2(cce_block_width_p / 8);
    localparam int unsigned lat_w_lp          = (cmd_latency_p > 1) ? $clog2(cmd_latency_p + 1) : 1;

    typedef enum logic [1:0] {
        e_ready,
        e_delay,
        e_send,
        e_wait_ack
    } state_e;

    state_e                      state_q;
    logic [lat_w_lp-1:0]         cnt_q;
    bp_lce_cmd_s                 cmd_q;
    logic                        cmd_v_q;
    logic                        cached_q;
    logic                        error_q;
    logic [lce_id_width_gp-1:0]  src_q;
    logic [paddr_width_gp-1:0]   blk_addr_q;
    logic [31:0]                 txn_q;

    bp_lce_cce_req_s  req_li;
    bp_lce_cce_resp_s resp_li;
    logic             req_hs_c, resp_hs_c, cmd_hs_c, ack_match_c, req_known_c, req_cached_c;

    // Clear the block-offset bits of an address.
    function automatic logic [paddr_width_gp-1:0] block_align(input logic [paddr_width_gp-1:0] a);
        return {a[paddr_width_gp-1:blk_off_w_lp], blk_off_w_lp'(0)};
    endfunction

    // Full-block fill: dword i = (base + 8*i) ^ seed.
    function automatic logic [cce_block_width_p-1:0] fill_data(input logic [paddr_width_gp-1:0] base);
        logic [cce_block_width_p-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < dwords_lp; i++) begin
            d[i*64 +: 64] = (64'(base) + 64'(8 * i)) ^ data_seed_p;
        end
        return d;
    endfunction

    // Command answering a request; only meaningful for the four known types.
    function automatic bp_lce_cmd_s build_cmd(input bp_lce_cce_req_s r);
        bp_lce_cmd_s c;
        c        = '0;
        c.dst_id = r.src_id;
        c.src_id = '0;
        case (r.msg_type)
            e_lce_req_type_rd, e_lce_req_type_wr: begin
                c.msg_type = e_lce_cmd_data;
                c.addr     = block_align(r.addr);
                c.way_id   = r.lru_way_id;
                c.size     = e_mem_msg_size_64;
                c.state    = (r.msg_type == e_lce_req_type_wr) ? e_COH_M
                           : (r.non_exclusive ? e_COH_S : e_COH_E);
                c.data     = fill_data(block_align(r.addr));
            end
            e_lce_req_type_uc_rd: begin
                c.msg_type    = e_lce_cmd_uc_data;
                c.addr        = r.addr;
                c.size        = r.size;
                c.data[63:0]  = 64'({r.addr[paddr_width_gp-1:3], 3'b000}) ^ data_seed_p;
            end
            e_lce_req_type_uc_wr: begin
                c.msg_type = e_lce_cmd_uc_st_done;
                c.addr     = r.addr;
                c.size     = r.size;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign req_li  = lce_req_i;
    assign resp_li = lce_resp_i;

    assign lce_req_ready_o  = ~reset_i & (state_q == e_ready);
    assign lce_resp_ready_o = ~reset_i;
    assign lce_cmd_o        = cmd_q;
    assign lce_cmd_v_o      = cmd_v_q;
    assign error_o          = error_q;
    assign txn_count_o      = txn_q;

    assign req_hs_c     = lce_req_v_i & lce_req_ready_o;
    assign resp_hs_c    = lce_resp_v_i & lce_resp_ready_o;
    assign cmd_hs_c     = cmd_v_q & lce_cmd_ready_i;
    assign req_cached_c = (req_li.msg_type == e_lce_req_type_rd) | (req_li.msg_type == e_lce_req_type_wr);
    assign req_known_c  = req_cached_c
                        | (req_li.msg_type == e_lce_req_type_uc_rd)
                        | (req_li.msg_type == e_lce_req_type_uc_wr);
    assign ack_match_c  = (resp_li.msg_type == e_lce_cce_coh_ack)
                        & (resp_li.src_id == src_q)
                        & (block_align(resp_li.addr) == blk_addr_q);

    // Transaction FSM with registered command, status and counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_ready;
            cnt_q      <= '0;
            cmd_q      <= '0;
            cmd_v_q    <= 1'b0;
            cached_q   <= 1'b0;
            error_q    <= 1'b0;
            src_q      <= '0;
            blk_addr_q <= '0;
            txn_q      <= '0;
        end else begin
            // Any response other than the awaited ack is a protocol violation.
            if (resp_hs_c && !(state_q == e_wait_ack && ack_match_c)) begin
                error_q <= 1'b1;
            end
            unique case (state_q)
                e_ready: begin
                    if (req_hs_c) begin
                        if (req_known_c) begin
                            cmd_q      <= build_cmd(req_li);
                            src_q      <= req_li.src_id;
                            blk_addr_q <= block_align(req_li.addr);
                            cached_q   <= req_cached_c;
                            cnt_q      <= lat_w_lp'(cmd_latency_p);
                            if (cmd_latency_p == 0) begin
                                state_q <= e_send;
                                cmd_v_q <= 1'b1;
                            end else begin
                                state_q <= e_delay;
                            end
                        end else begin
                            // Unknown request type is consumed without a command.
                            error_q <= 1'b1;
                        end
                    end
                end
                e_delay: begin
                    if (cnt_q == '0) begin
                        state_q <= e_send;
                        cmd_v_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - lat_w_lp'(1);
                    end
                end
                e_send: begin
                    if (cmd_hs_c) begin
                        cmd_v_q <= 1'b0;
                        if (cached_q) begin
                            state_q <= e_wait_ack;
                        end else begin
                            state_q <= e_ready;
                            txn_q   <= txn_q + 32'd1;
                        end
                    end
                end
                e_wait_ack: begin
                    if (resp_hs_c && ack_match_c) begin
                        state_q <= e_ready;
                        txn_q   <= txn_q + 32'd1;
                    end
                end
                default: state_q <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_nonsynth_mock_cce_responder.sv
// Bench for the mock CCE responder: directed scenarios plus randomized
// transactions compared against an address-arithmetic reference model.
module tb_bp_me_nonsynth_mock_cce_responder;
    import bp_me_nonsynth_mock_cce_responder_pkg::*;

    localparam int unsigned lat_lp   = 2;
    localparam logic [63:0] seed_lp  = 64'hFF;
    localparam int unsigned req_w_lp = $bits(bp_lce_cce_req_s);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_i;
    logic [req_w_lp-1:0]  req_bits;
    logic                 req_v, req_ready;
    bp_lce_cce_resp_s     resp;
    logic                 resp_v, resp_ready;
    bp_lce_cmd_s          cmd;
    logic                 cmd_v, cmd_ready;
    logic                 err;
    logic [31:0]          txn;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          exp_err;
    int unsigned exp_txn;
    bp_lce_cmd_s last_cmd;

    bp_me_nonsynth_mock_cce_responder #(
        .bp_params_p   (e_bp_unicore_half_cfg),
        .cmd_latency_p (lat_lp),
        .data_seed_p   (seed_lp)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .lce_req_i        (req_bits),
        .lce_req_v_i      (req_v),
        .lce_req_ready_o  (req_ready),
        .lce_resp_i       (resp),
        .lce_resp_v_i     (resp_v),
        .lce_resp_ready_o (resp_ready),
        .lce_cmd_o        (cmd),
        .lce_cmd_v_o      (cmd_v),
        .lce_cmd_ready_i  (cmd_ready),
        .error_o          (err),
        .txn_count_o      (txn)
    );

    task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: expected command from the request, by plain address arithmetic.
    function automatic bp_lce_cmd_s model_cmd(input bp_lce_cce_req_s r);
        bp_lce_cmd_s     m;
        longint unsigned a, base;
        m      = '0;
        a      = 64'(r.addr);
        base   = (a / 64) * 64;
        m.dst_id = r.src_id;
        if (r.msg_type == e_lce_req_type_rd || r.msg_type == e_lce_req_type_wr) begin
            m.msg_type = e_lce_cmd_data;
            m.addr     = 40'(base);
            m.way_id   = r.lru_way_id;
            m.size     = e_mem_msg_size_64;
            if (r.msg_type == e_lce_req_type_wr) m.state = e_COH_M;
            else if (r.non_exclusive)            m.state = e_COH_S;
            else                                 m.state = e_COH_E;
            for (int i = 0; i < 8; i++) m.data[i*64 +: 64] = (base + 64'(8 * i)) ^ seed_lp;
        end else if (r.msg_type == e_lce_req_type_uc_rd) begin
            m.msg_type    = e_lce_cmd_uc_data;
            m.addr        = r.addr;
            m.size        = r.size;
            m.data[63:0]  = ((a / 8) * 8) ^ seed_lp;
        end else begin
            m.msg_type = e_lce_cmd_uc_st_done;
        end
        return m;
    endfunction

    function automatic bp_lce_cce_req_s mk_req(input bp_lce_cce_req_type_e t, input logic [39:0] a,
                                               input logic [3:0] s, input logic [2:0] lru,
                                               input logic ne, input bp_mem_msg_size_e sz);
        bp_lce_cce_req_s r;
        r.msg_type = t; r.addr = a; r.src_id = s; r.lru_way_id = lru;
        r.non_exclusive = ne; r.size = sz;
        return r;
    endfunction

    task automatic pulse_resp(input bp_lce_cce_resp_type_e t, input logic [39:0] a, input logic [3:0] s);
        resp.msg_type = t; resp.addr = a; resp.src_id = s; resp_v = 1'b1;
        @(posedge clk); #1;
        resp_v = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_resp_ready", resp_ready, 0);
        check_eq("rst_cmd_v", cmd_v, 0);
        check_eq("rst_cmd", cmd, 0);
        check_eq("rst_error", err, 0);
        check_eq("rst_txn", txn, 0);
        reset_i = 1'b0;
        #1;
        check_eq("post_rst_req_ready", req_ready, 1);
        check_eq("post_rst_resp_ready", resp_ready, 1);
        exp_err = 1'b0;
        exp_txn = 0;
    endtask

    // One request through to completion; bad_ack: 0 none, 1 wrong src, 2 wrong block, 3 wrong type.
    task automatic do_txn(input bp_lce_cce_req_s r, input bit invalid, input int stall,
                          input int bad_ack, input bit simul);
        bp_lce_cmd_s     exp_c, first;
        int              cyc;
        bit              ready_leak, unstable, cached;
        longint unsigned base;
        exp_c  = model_cmd(r);
        cached = !invalid && (r.msg_type == e_lce_req_type_rd || r.msg_type == e_lce_req_type_wr);
        base   = (64'(r.addr) / 64) * 64;
        req_bits = r;
        if (invalid) req_bits[req_w_lp-1 -: 3] = 3'($urandom_range(4, 7));
        req_v = 1'b1;
        if (simul) begin
            resp.msg_type = e_lce_cce_coh_ack; resp.src_id = r.src_id; resp.addr = 40'(base);
            resp_v = 1'b1;
        end
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_eq("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_v = 1'b0; resp_v = 1'b0;
        if (simul || invalid) exp_err = 1'b1;
        if (invalid) begin
            cyc = 0;
            repeat (lat_lp + 3) begin @(posedge clk); #1; if (cmd_v) cyc++; end
            check_eq("invalid_no_cmd", cyc, 0);
            check_eq("invalid_ready", req_ready, 1);
            check_eq("error", err, exp_err);
            return;
        end
        cyc = 0; ready_leak = 0;
        while (!cmd_v && cyc < 20) begin
            if (req_ready) ready_leak = 1;
            @(posedge clk); #1; cyc++;
        end
        check_eq("cmd_latency", cyc, lat_lp + 1);
        check_eq("busy_ready_low", ready_leak, 0);
        if (!cmd_v) return;
        first = cmd; unstable = 0;
        repeat (stall) begin
            @(posedge clk); #1;
            if (cmd !== first || !cmd_v || req_ready) unstable = 1;
        end
        check_eq("cmd_stable", unstable, 0);
        check_eq("cmd_type", 640'(cmd.msg_type), 640'(exp_c.msg_type));
        check_eq("cmd_dst", cmd.dst_id, exp_c.dst_id);
        check_eq("cmd_src", cmd.src_id, 0);
        check_eq("cmd_data", cmd.data, exp_c.data);
        if (exp_c.msg_type != e_lce_cmd_uc_st_done) begin
            check_eq("cmd_addr", cmd.addr, exp_c.addr);
            check_eq("cmd_size", 640'(cmd.size), 640'(exp_c.size));
        end
        if (cached) begin
            check_eq("cmd_way", cmd.way_id, exp_c.way_id);
            check_eq("cmd_state", 640'(cmd.state), 640'(exp_c.state));
        end
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        last_cmd = first;
        check_eq("cmd_v_drop", cmd_v, 0);
        if (!cached) begin
            exp_txn++;
            check_eq("uc_ready_next", req_ready, 1);
        end else begin
            check_eq("await_ack_ready", req_ready, 0);
            if (bad_ack != 0) begin
                pulse_resp((bad_ack == 3) ? e_lce_cce_inv_ack : e_lce_cce_coh_ack,
                           40'(base + ((bad_ack == 2) ? 64 : 0) + 64'($urandom_range(0, 63))),
                           (bad_ack == 1) ? (r.src_id ^ 4'd1) : r.src_id);
                exp_err = 1'b1;
                check_eq("bad_ack_error", err, exp_err);
                check_eq("bad_ack_holds", req_ready, 0);
            end
            pulse_resp(e_lce_cce_coh_ack, 40'(base + 64'($urandom_range(0, 63))), r.src_id);
            exp_txn++;
            check_eq("ack_ready", req_ready, 1);
        end
        check_eq("txn_count", txn, exp_txn);
        check_eq("error", err, exp_err);
    endtask

    initial begin
        bp_lce_cce_req_s r;
        int              cyc;
        reset_i = 1'b1; req_v = 1'b0; resp_v = 1'b0; cmd_ready = 1'b0;
        req_bits = '0; resp = '0;
        exp_err = 1'b0; exp_txn = 0; last_cmd = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Exclusive read fill and its first-dword arithmetic.
        do_txn(mk_req(e_lce_req_type_rd, 40'h00_8000_0040, 4'd0, 3'd3, 1'b0, e_mem_msg_size_8), 0, 0, 0, 0);
        check_eq("rd_dword1", last_cmd.data[127:64], 64'h0000_0000_8000_0048 ^ seed_lp);
        check_eq("rd_txn1", txn, 1);

        // Shared read then write to the same block, with a command stall.
        do_txn(mk_req(e_lce_req_type_rd, 40'h00_8000_0080, 4'd2, 3'd1, 1'b1, e_mem_msg_size_8), 0, 5, 0, 0);
        do_txn(mk_req(e_lce_req_type_wr, 40'h00_8000_0088, 4'd2, 3'd5, 1'b0, e_mem_msg_size_8), 0, 5, 0, 0);

        // Uncached read: 8-byte aligned address pattern in dword 0 only.
        do_txn(mk_req(e_lce_req_type_uc_rd, 40'h00_0000_1004, 4'd1, 3'd0, 1'b0, e_mem_msg_size_4), 0, 0, 0, 0);
        check_eq("uc_dword0", last_cmd.data[63:0], 64'h0000_0000_0000_1000 ^ seed_lp);
        check_eq("uc_upper_zero", last_cmd.data[511:64], 0);

        // Uncached store, then a stray ack in idle sets the sticky error.
        do_txn(mk_req(e_lce_req_type_uc_wr, 40'h00_0000_2000, 4'd1, 3'd0, 1'b0, e_mem_msg_size_8), 0, 2, 0, 0);
        pulse_resp(e_lce_cce_coh_ack, 40'h00_0000_2000, 4'd1);
        exp_err = 1'b1;
        check_eq("stray_ack_error", err, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("stray_ack_sticky", err, 1);
        do_reset();

        // Ack from the wrong LCE is flagged and ignored; the right one completes.
        do_txn(mk_req(e_lce_req_type_rd, 40'h00_4000_01C0, 4'd0, 3'd2, 1'b0, e_mem_msg_size_8), 0, 1, 1, 0);
        // Request and response together in idle: both accepted, response is an error.
        do_txn(mk_req(e_lce_req_type_uc_rd, 40'h00_4000_0008, 4'd3, 3'd0, 1'b0, e_mem_msg_size_8), 0, 0, 0, 1);
        // Unknown request type is consumed without a command.
        do_txn(mk_req(e_lce_req_type_rd, 40'h00_0000_0400, 4'd0, 3'd0, 1'b0, e_mem_msg_size_8), 1, 0, 0, 0);

        // Reset while the command is being offered abandons it.
        req_bits = mk_req(e_lce_req_type_rd, 40'h00_0000_0800, 4'd4, 3'd6, 1'b0, e_mem_msg_size_8);
        req_v = 1'b1;
        @(posedge clk); #1;
        req_v = 1'b0;
        cyc = 0;
        while (!cmd_v && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_eq("pre_rst_cmd_v", cmd_v, 1);
        do_reset();
        cyc = 0;
        repeat (6) begin @(posedge clk); #1; if (cmd_v) cyc++; end
        check_eq("abandoned_no_cmd", cyc, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int t;
            t = int'($urandom_range(0, 9));
            r.msg_type      = (t < 3) ? e_lce_req_type_rd : (t < 5) ? e_lce_req_type_wr
                            : (t < 7) ? e_lce_req_type_uc_rd : e_lce_req_type_uc_wr;
            r.addr          = {8'($urandom_range(0, 255)), 32'($urandom)};
            r.src_id        = 4'($urandom_range(0, 15));
            r.lru_way_id    = 3'($urandom_range(0, 7));
            r.non_exclusive = 1'($urandom_range(0, 1));
            r.size          = bp_mem_msg_size_e'(3'($urandom_range(0, 3)));
            do_txn(r, (t == 9), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   ($urandom_range(0, 7) == 0));
            if (n == 25) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
